// File: rtl/uart_rx_buffer.sv
// Byte FIFO behind uart_rx that serves the core one byte or one 32-bit word per read.
// Define UART_RX_WORD_BE_EN to pack word reads big-endian (earliest byte in dout[31:24]).
module uart_rx_buffer #(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rdata,
  input  logic              rx_ready,
  input  logic              ferr,
  input  logic              rd_en,
  input  logic              rd_word,
  input  logic              clr_err,
  output logic [31:0]       dout,
  output logic              dout_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              word_avail,
  output logic              overflow,
  output logic              ferr_seen
);

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] L_WORD  = (ADDR_W + 1)'(4);
  localparam logic [ADDR_W:0] L_ONE   = (ADDR_W + 1)'(1);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_dout;
  logic              r_dout_valid;
  logic              r_overflow;
  logic              r_ferr_seen;

  logic              w_wr_accept;
  logic              w_ovf_set;
  logic              w_ferr_set;
  logic              w_rd_byte;
  logic              w_rd_word;
  logic [ADDR_W:0]   w_pop;
  logic [31:0]       w_dout_next;
  logic [31:0]       w_word;
  logic [7:0]        w_b [4];

  // All acceptance decisions look at the count held before this edge.
  assign w_wr_accept = rx_ready && !ferr && (r_count != L_DEPTH);
  assign w_ovf_set   = rx_ready && !ferr && (r_count == L_DEPTH);
  assign w_ferr_set  = rx_ready && ferr;
  assign w_rd_byte   = rd_en && !rd_word && (r_count != '0);
  assign w_rd_word   = rd_en && rd_word && (r_count >= L_WORD);

  for (genvar gi = 0; gi < 4; gi++) begin : g_word_bytes
    assign w_b[gi] = r_mem[r_rd_ptr + ADDR_W'(gi)];
  end

`ifdef UART_RX_WORD_BE_EN
  assign w_word = {w_b[0], w_b[1], w_b[2], w_b[3]};
`else
  assign w_word = {w_b[3], w_b[2], w_b[1], w_b[0]};
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that skipped one would infer a latch.
    w_pop       = '0;
    w_dout_next = r_dout;
    if (w_rd_word) begin
      w_pop       = L_WORD;
      w_dout_next = w_word;
    end else if (w_rd_byte) begin
      w_pop       = L_ONE;
      w_dout_next = {24'h0, w_b[0]};
    end
  end

  // NOTE: storage carries no reset; pointers and count define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_accept) begin
      r_mem[r_wr_ptr] <= rdata;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every update sees pre-edge values.
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_ferr_seen  <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      r_rd_ptr     <= r_rd_ptr + w_pop[ADDR_W-1:0];
      r_count      <= r_count + {{ADDR_W{1'b0}}, w_wr_accept} - w_pop;
      r_dout       <= w_dout_next;
      r_dout_valid <= w_rd_byte || w_rd_word;
      // A new error in the clearing cycle keeps the flag set.
      r_overflow   <= w_ovf_set || (r_overflow && !clr_err);
      r_ferr_seen  <= w_ferr_set || (r_ferr_seen && !clr_err);
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign count      = r_count;
  assign empty      = (r_count == '0);
  assign full       = (r_count == L_DEPTH);
  assign word_avail = (r_count >= L_WORD);
  assign overflow   = r_overflow;
  assign ferr_seen  = r_ferr_seen;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_uart_rx_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rdata;
  logic              rx_ready;
  logic              ferr;
  logic              rd_en;
  logic              rd_word;
  logic              clr_err;
  logic [31:0]       dout;
  logic              dout_valid;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              word_avail;
  logic              overflow;
  logic              ferr_seen;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  m_q [$];
  logic [31:0] m_dout;
  logic        m_dv;
  logic        m_ov;
  logic        m_fs;

  uart_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdata      (rdata),
    .rx_ready   (rx_ready),
    .ferr       (ferr),
    .rd_en      (rd_en),
    .rd_word    (rd_word),
    .clr_err    (clr_err),
    .dout       (dout),
    .dout_valid (dout_valid),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .word_avail (word_avail),
    .overflow   (overflow),
    .ferr_seen  (ferr_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
`ifdef UART_RX_WORD_BE_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  // Apply the rules for one clock edge, using the inputs that were stable across it.
  task automatic model_update();
    int          pre;
    logic [7:0]  b [4];
    pre = m_q.size();
    if (rst) begin
      m_q.delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_ov   = 1'b0;
      m_fs   = 1'b0;
    end else begin
      m_dv = 1'b0;
      if (rd_en && !rd_word && pre >= 1) begin
        m_dout = {24'h0, m_q.pop_front()};
        m_dv   = 1'b1;
      end else if (rd_en && rd_word && pre >= 4) begin
        for (int i = 0; i < 4; i++) b[i] = m_q.pop_front();
        m_dout = pack_word(b[0], b[1], b[2], b[3]);
        m_dv   = 1'b1;
      end
      if (clr_err) begin
        m_ov = 1'b0;
        m_fs = 1'b0;
      end
      if (rx_ready) begin
        if (ferr)              m_fs = 1'b1;
        else if (pre == DEPTH) m_ov = 1'b1;
        else                   m_q.push_back(rdata);
      end
    end
  endtask

  task automatic compare_all();
    check("count",      32'(count),      32'(m_q.size()));
    check("empty",      32'(empty),      32'(m_q.size() == 0));
    check("full",       32'(full),       32'(m_q.size() == DEPTH));
    check("word_avail", 32'(word_avail), 32'(m_q.size() >= 4));
    check("overflow",   32'(overflow),   32'(m_ov));
    check("ferr_seen",  32'(ferr_seen),  32'(m_fs));
    check("dout_valid", 32'(dout_valid), 32'(m_dv));
    check("dout",       dout,            m_dout);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
    compare_all();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; rdata = '0; rx_ready = 1'b0; ferr = 1'b0;
    rd_en = 1'b0; rd_word = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1'b1; tick(); idle_inputs();
  endtask

  task automatic push(input logic [7:0] b);
    idle_inputs(); rx_ready = 1'b1; rdata = b; tick(); idle_inputs();
  endtask

  task automatic rd(input logic w);
    idle_inputs(); rd_en = 1'b1; rd_word = w; tick(); idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_dout = '0; m_dv = 1'b0; m_ov = 1'b0; m_fs = 1'b0;

    // Reset state
    do_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_dout",  dout,       32'd0);

    // Four bytes, one word read
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    check("tp1_count4", 32'(count), 32'd4);
    check("tp1_wavail", 32'(word_avail), 32'd1);
    rd(1'b1);
`ifdef UART_RX_WORD_BE_EN
    check("tp1_word", dout, 32'h11223344);
`else
    check("tp1_word", dout, 32'h44332211);
`endif
    check("tp1_dv",    32'(dout_valid), 32'd1);
    check("tp1_empty", 32'(empty),      32'd1);

    // Byte read, then pulse ends, then read from empty is ignored
    push(8'hA5);
    rd(1'b0);
    check("tp2_byte", dout, 32'h000000A5);
    check("tp2_dv",   32'(dout_valid), 32'd1);
    rd(1'b0);
    check("tp2_empty_dv",   32'(dout_valid), 32'd0);
    check("tp2_empty_hold", dout, 32'h000000A5);

    // Word read with only 3 bytes is ignored; retry after the 4th
    push(8'h01); push(8'h02); push(8'h03);
    rd(1'b1);
    check("tp3_ign_dv",    32'(dout_valid), 32'd0);
    check("tp3_ign_count", 32'(count),      32'd3);
    push(8'h04);
    rd(1'b1);
`ifdef UART_RX_WORD_BE_EN
    check("tp3_word", dout, 32'h01020304);
`else
    check("tp3_word", dout, 32'h04030201);
`endif

    // Overflow: DEPTH+1 pushes, the last is lost
    for (int i = 0; i <= DEPTH; i++) push(8'(i));
    check("tp4_full", 32'(full),     32'd1);
    check("tp4_ovf",  32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      rd(1'b0);
      check("tp4_order", dout, 32'(i));
    end
    check("tp4_empty", 32'(empty), 32'd1);
    idle_inputs(); clr_err = 1'b1; tick(); idle_inputs();
    check("tp4_clr", 32'(overflow), 32'd0);

    // Framing error drops the byte
    push(8'h5A);
    idle_inputs(); rx_ready = 1'b1; ferr = 1'b1; rdata = 8'hFF; tick(); idle_inputs();
    check("tp5_count", 32'(count),     32'd1);
    check("tp5_fs",    32'(ferr_seen), 32'd1);
    // Clear and a new error in the same cycle: set wins
    idle_inputs(); clr_err = 1'b1; rx_ready = 1'b1; ferr = 1'b1; tick(); idle_inputs();
    check("tp5_setwins", 32'(ferr_seen), 32'd1);

    // Wrap with simultaneous write and word read
    do_reset();
    for (int i = 0; i < DEPTH - 2; i++) push(8'(i));
    for (int i = 0; i < DEPTH - 2; i++) rd(1'b0);
    for (int i = 0; i < DEPTH - 1; i++) push(8'(8'h80 + i));
    check("tp6_pre", 32'(count), 32'(DEPTH - 1));
    idle_inputs(); rd_en = 1'b1; rd_word = 1'b1; rx_ready = 1'b1; rdata = 8'hEE; tick(); idle_inputs();
    check("tp6_count", 32'(count),    32'(DEPTH - 4));
    check("tp6_ovf",   32'(overflow), 32'd0);
`ifdef UART_RX_WORD_BE_EN
    check("tp6_word", dout, 32'h80818283);
`else
    check("tp6_word", dout, 32'h83828180);
`endif

    // Reset mid-stream, with a byte arriving in the reset cycle
    rd(1'b0);
    idle_inputs(); rst = 1'b1; rx_ready = 1'b1; rdata = 8'h77; tick(); idle_inputs();
    check("tp7_count", 32'(count),      32'd0);
    check("tp7_dout",  dout,            32'd0);
    check("tp7_dv",    32'(dout_valid), 32'd0);
    check("tp7_ovf",   32'(overflow),   32'd0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      rst      = ($urandom_range(0, 299) == 0);
      rx_ready = ($urandom_range(0, 99) < 55);
      ferr     = ($urandom_range(0, 99) < 5);
      rdata    = 8'($urandom);
      rd_en    = ($urandom_range(0, 99) < 45);
      rd_word  = ($urandom_range(0, 99) < 40);
      clr_err  = ($urandom_range(0, 99) < 3);
      tick();
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
